// File: rtl/quad_phase_decoder.sv
// Quadrature phase decoder: synchronises two phase inputs, decodes Gray-code
// steps into direction and a wrapping position, measures the interval between
// steps and flags illegal transitions and stalls.
//
// state | meaning
// PRIME | waiting for the synchronisers to fill after reset; prev is loaded at the end
// TRACK | comparing cur with prev every cycle and decoding steps
module quad_phase_decoder #(
   parameter int POS_W       = 16,
   parameter int PER_W       = 20,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             qa_i,
   input  logic             qb_i,
   input  logic             clr_i,
   output logic             step_o,
   output logic             dir_o,
   output logic [POS_W-1:0] pos_o,
   output logic             err_o,
   output logic [7:0]       err_cnt_o,
   output logic [PER_W-1:0] period_o,
   output logic             per_valid_o,
   output logic             stall_o
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("quad_phase_decoder: SYNC_STAGES must be at least 2");
   end

   localparam int CNT_W = $clog2(SYNC_STAGES + 1);
   localparam logic [PER_W-1:0] PER_MAX = '1;

   typedef enum logic {PRIME, TRACK} state_t;

   logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
   logic [1:0]             cur;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       prime_cnt_q, prime_cnt_d;
   logic [1:0]             prev_q, prev_d;
   logic                   fwd_q, fwd_d, rev_q, rev_d, ill_q, ill_d;
   logic                   step_q, step_d, dir_q, dir_d, err_q, err_d;
   logic [POS_W-1:0]       pos_q, pos_d;
   logic [7:0]             err_cnt_q, err_cnt_d;
   logic [PER_W-1:0]       timer_q, timer_d, period_q, period_d;
   logic                   per_valid_q, per_valid_d, stall_q, stall_d;
   logic                   have_prev_q, have_prev_d;

   // Next {a,b} code one forward step after the given code
   function automatic logic [1:0] fwd_next(input logic [1:0] code);
      case (code)
         2'b00:   fwd_next = 2'b10;
         2'b10:   fwd_next = 2'b11;
         2'b11:   fwd_next = 2'b01;
         default: fwd_next = 2'b00;
      endcase
   endfunction

   // Input synchronisers for both phases
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         a_sync_q <= '0;
         b_sync_q <= '0;
      end else begin
         a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], qa_i};
         b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], qb_i};
      end
   end

   assign cur = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

   // FSM state, prime counter, previous code and decoded-event register
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q     <= PRIME;
         prime_cnt_q <= CNT_W'(SYNC_STAGES);
         prev_q      <= 2'b00;
         fwd_q       <= 1'b0;
         rev_q       <= 1'b0;
         ill_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         prime_cnt_q <= prime_cnt_d;
         prev_q      <= prev_d;
         fwd_q       <= fwd_d;
         rev_q       <= rev_d;
         ill_q       <= ill_d;
      end
   end

   // Next-state logic and transition decode
   always_comb begin
      state_d     = state_q;
      prime_cnt_d = prime_cnt_q;
      prev_d      = prev_q;
      fwd_d       = 1'b0;
      rev_d       = 1'b0;
      ill_d       = 1'b0;
      case (state_q)
         PRIME: begin
            if (prime_cnt_q == '0) begin
               prev_d  = cur;
               state_d = TRACK;
            end else begin
               prime_cnt_d = prime_cnt_q - 1'b1;
            end
         end
         TRACK: begin
            prev_d = cur;
            if (cur != prev_q) begin
               if (cur == fwd_next(prev_q))      fwd_d = 1'b1;
               else if (prev_q == fwd_next(cur)) rev_d = 1'b1;
               else                              ill_d = 1'b1;
            end
         end
         default: state_d = PRIME;
      endcase
   end

   // Output datapath: position, error count, period timer and stall
   always_comb begin
      step_d      = fwd_q | rev_q;
      err_d       = ill_q;
      dir_d       = dir_q;
      pos_d       = pos_q;
      err_cnt_d   = err_cnt_q;
      timer_d     = timer_q;
      period_d    = period_q;
      per_valid_d = per_valid_q;
      stall_d     = stall_q;
      have_prev_d = have_prev_q;

      if (fwd_q)      dir_d = 1'b1;
      else if (rev_q) dir_d = 1'b0;

      if (clr_i)      pos_d = '0;
      else if (fwd_q) pos_d = pos_q + 1'b1;
      else if (rev_q) pos_d = pos_q - 1'b1;

      if (clr_i)                            err_cnt_d = '0;
      else if (ill_q && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 1'b1;

      if (state_q == TRACK) begin
         if (step_d)                 timer_d = PER_W'(1);
         else if (timer_q != PER_MAX) timer_d = timer_q + 1'b1;
      end

      // A saturated timer at a step means the interval is unknown
      if (step_d) begin
         have_prev_d = 1'b1;
         stall_d     = 1'b0;
         if (have_prev_q && timer_q != PER_MAX) begin
            period_d    = timer_q;
            per_valid_d = 1'b1;
         end else begin
            per_valid_d = 1'b0;
         end
      end else if (timer_d == PER_MAX) begin
         stall_d     = 1'b1;
         per_valid_d = 1'b0;
      end
   end

   // Registered outputs
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         step_q      <= 1'b0;
         dir_q       <= 1'b0;
         err_q       <= 1'b0;
         pos_q       <= '0;
         err_cnt_q   <= '0;
         timer_q     <= '0;
         period_q    <= '0;
         per_valid_q <= 1'b0;
         stall_q     <= 1'b0;
         have_prev_q <= 1'b0;
      end else begin
         step_q      <= step_d;
         dir_q       <= dir_d;
         err_q       <= err_d;
         pos_q       <= pos_d;
         err_cnt_q   <= err_cnt_d;
         timer_q     <= timer_d;
         period_q    <= period_d;
         per_valid_q <= per_valid_d;
         stall_q     <= stall_d;
         have_prev_q <= have_prev_d;
      end
   end

   assign step_o      = step_q;
   assign dir_o       = dir_q;
   assign err_o       = err_q;
   assign pos_o       = pos_q;
   assign err_cnt_o   = err_cnt_q;
   assign period_o    = period_q;
   assign per_valid_o = per_valid_q;
   assign stall_o     = stall_q;

endmodule

// File: tb/tb_quad_phase_decoder.sv
// Directed bench for quad_phase_decoder: a default instance and a PER_W=8
// instance share the same stimulus; the small instance is used for stall tests.
module tb_quad_phase_decoder;

   logic        clk = 1'b0;
   logic        rst, qa, qb, clr;
   logic        step, dir, err, per_valid, stall;
   logic [15:0] pos;
   logic [7:0]  err_cnt;
   logic [19:0] period;
   logic        step8, dir8, err8, per_valid8, stall8;
   logic [15:0] pos8;
   logic [7:0]  err_cnt8;
   logic [7:0]  period8;

   int nvec = 0;
   int nerr = 0;
   int n_step, n_err;

   always #5 clk = ~clk;

   quad_phase_decoder u_dut (
      .clk_i(clk), .rst_i(rst), .qa_i(qa), .qb_i(qb), .clr_i(clr),
      .step_o(step), .dir_o(dir), .pos_o(pos), .err_o(err), .err_cnt_o(err_cnt),
      .period_o(period), .per_valid_o(per_valid), .stall_o(stall)
   );

   quad_phase_decoder #(.PER_W(8)) u_dut8 (
      .clk_i(clk), .rst_i(rst), .qa_i(qa), .qb_i(qb), .clr_i(clr),
      .step_o(step8), .dir_o(dir8), .pos_o(pos8), .err_o(err8), .err_cnt_o(err_cnt8),
      .period_o(period8), .per_valid_o(per_valid8), .stall_o(stall8)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_ab(input logic [1:0] ab);
      qa = ab[1];
      qb = ab[0];
   endtask

   initial begin
      logic [1:0] fwd_seq [4];
      fwd_seq[0] = 2'b10; fwd_seq[1] = 2'b11; fwd_seq[2] = 2'b01; fwd_seq[3] = 2'b00;
      rst = 1'b0; clr = 1'b0; qa = 1'b1; qb = 1'b1;

      // Reset with both phases high, then idle
      tick(3);
      chk("rst_step", step, 0);   chk("rst_err", err, 0);
      chk("rst_pos", pos, 0);     chk("rst_dir", dir, 0);
      chk("rst_errcnt", err_cnt, 0);
      chk("rst_period", period, 0); chk("rst_pvalid", per_valid, 0);
      chk("rst_stall", stall, 0);
      rst = 1'b1;
      n_step = 0; n_err = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         n_step += int'(step);
         n_err  += int'(err);
      end
      chk("idle11_steps", n_step, 0); chk("idle11_errs", n_err, 0);
      chk("idle11_pos", pos, 0);      chk("idle11_stall", stall, 0);

      // Restart from 00 and run one forward cycle, 8 cycles per code
      rst = 1'b0; set_ab(2'b00);
      tick(2);
      rst = 1'b1;
      tick(10);
      for (int i = 0; i < 4; i++) begin
         set_ab(fwd_seq[i]);
         tick(3);
         chk("fwd_latency_early", step, 0);
         tick(1);
         chk("fwd_step", step, 1);
         chk("fwd_dir", dir, 1);
         chk("fwd_pos", pos, i + 1);
         chk("fwd_pvalid", per_valid, (i == 0) ? 0 : 1);
         if (i > 0) chk("fwd_period", period, 8);
         tick(1);
         chk("fwd_pulse_width", step, 0);
         tick(3);
      end

      // Reverse across zero and back
      clr = 1'b1; tick(1); clr = 1'b0;
      chk("clr_pos", pos, 0);
      set_ab(2'b01); tick(4);
      chk("rev_step", step, 1); chk("rev_pos", pos, 16'hFFFF); chk("rev_dir", dir, 0);
      tick(4);
      set_ab(2'b00); tick(4);
      chk("fwd_wrap_pos", pos, 0); chk("fwd_wrap_dir", dir, 1);
      tick(4);

      // Illegal jump, then saturate the error count
      set_ab(2'b11); tick(3);
      chk("ill_early", err, 0);
      tick(1);
      chk("ill_err", err, 1); chk("ill_step", step, 0);
      chk("ill_errcnt", err_cnt, 1); chk("ill_pos", pos, 0); chk("ill_dir", dir, 1);
      tick(1);
      chk("ill_pulse_width", err, 0);
      for (int i = 0; i < 300; i++) begin
         qa = ~qa; qb = ~qb;
         tick(1);
      end
      tick(5);
      chk("errcnt_sat", err_cnt, 255);
      chk("errcnt_sat_pos", pos, 0);

      // Forward five steps from 11, then clear on the same edge as a reverse step
      set_ab(2'b01); tick(4);
      set_ab(2'b00); tick(4);
      set_ab(2'b10); tick(4);
      set_ab(2'b11); tick(4);
      set_ab(2'b01); tick(4);
      chk("pos_five", pos, 5);
      set_ab(2'b11); tick(3);
      clr = 1'b1; tick(1); clr = 1'b0;
      chk("clr_step", step, 1); chk("clr_pos_pri", pos, 0);
      chk("clr_dir", dir, 0);   chk("clr_errcnt", err_cnt, 0);
      tick(4);

      // Reset mid-sequence with a step about to emerge
      set_ab(2'b01); tick(4);
      set_ab(2'b00); tick(4);
      set_ab(2'b10); tick(4);
      chk("pos_three", pos, 3);
      set_ab(2'b11); tick(3);
      rst = 1'b0; tick(1); rst = 1'b1;
      chk("mid_rst_step", step, 0);   chk("mid_rst_pos", pos, 0);
      chk("mid_rst_dir", dir, 0);     chk("mid_rst_errcnt", err_cnt, 0);
      chk("mid_rst_period", period, 0); chk("mid_rst_pvalid", per_valid, 0);
      chk("mid_rst_stall", stall, 0); chk("mid_rst_err", err, 0);
      tick(10);
      chk("post_rst_pos", pos, 0);

      // Stall detection on the PER_W=8 instance
      set_ab(2'b01); tick(4);
      chk("st_step1", step8, 1); chk("st_pvalid1", per_valid8, 0);
      tick(2);
      set_ab(2'b00); tick(4);
      chk("st_step2", step8, 1); chk("st_period2", period8, 6); chk("st_pvalid2", per_valid8, 1);
      tick(253);
      chk("st_before", stall8, 0);
      tick(1);
      chk("st_at_254", stall8, 1); chk("st_pvalid_clr", per_valid8, 0);
      tick(46);
      chk("st_hold", stall8, 1); chk("st_wide_no_stall", stall, 0);
      set_ab(2'b10); tick(4);
      chk("st_release", stall8, 0); chk("st_period_kept", period8, 6);
      chk("st_pvalid_first", per_valid8, 0);
      chk("wide_period_304", period, 304); chk("wide_pvalid", per_valid, 1);
      tick(4);
      set_ab(2'b11); tick(4);
      chk("st_period8", period8, 8); chk("st_pvalid8", per_valid8, 1);
      chk("st_pos", pos8, 4);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/quad_phase_decoder.md
Name: quad_phase_decoder

Overview:
- Downstream consumer of the two-phase toggle generator outputs Q1/Q2, which toggle at staggered counter values to form a quadrature-like pair.
- Synchronises both phases and decodes the Gray-code transitions into step pulses, direction and a wrapping position count.
- Measures the clock cycles between consecutive steps and flags illegal transitions and stalls.
- Used to close the loop on, and to verify, the phase generator in hardware.

Parameters:
- POS_W, 16: position counter width; wraps modulo 2^POS_W.
- PER_W, 20: step-period timer width; saturates at 2^PER_W-1.
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser; values below 2 are illegal.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- qa  in  1  phase A (from Q1); asynchronous.
- qb  in  1  phase B (from Q2); asynchronous.
- clr  in  1  synchronous clear of pos and err_cnt.
- step  out  1  one-cycle pulse per valid transition.
- dir  out  1  1 = forward, 0 = reverse; direction of the last valid step.
- pos  out  POS_W  signed position, two's complement, wraps.
- err  out  1  one-cycle pulse on an illegal transition (both bits change).
- err_cnt  out  8  illegal-transition count; saturates at 255.
- period  out  PER_W  cycles between the last two valid steps.
- per_valid  out  1  period holds a valid measurement.
- stall  out  1  no valid step for 2^PER_W-1 cycles.

Behaviour:
- Reset (rst=0 at an edge): synchronisers, prev and all outputs go to 0; timer goes to 0; FSM goes to PRIME. Reset overrides everything, including mid-sequence.
- Synchroniser: qa and qb each pass through SYNC_STAGES flops. cur = {a_sync, b_sync}.
- FSM state PRIME: counts SYNC_STAGES+1 cycles after reset release, then loads prev <= cur and moves to TRACK. No step or err is produced in PRIME, so any input level at reset release is legal.
- FSM state TRACK: compares cur with prev every cycle, then sets prev <= cur.
- Forward sequence {a,b}: 00->10->11->01->00.
- Reverse sequence: the same sequence in the opposite order.
- Valid forward step: registered outputs update at the next edge: step=1, dir=1, pos=pos+1.
- Valid reverse step: step=1, dir=0, pos=pos-1.
- No change (cur == prev): step=0, err=0; pos and dir hold.
- Illegal transition (00<->11 or 10<->01): err=1, err_cnt=min(err_cnt+1, 255); pos and dir unchanged; no step; timer not reset.
- Latency: an input change first sampled at edge k produces step/err at the output after edge k+SYNC_STAGES+1. Outputs are fully registered.
- pos arithmetic: wraps 0x7FFF -> 0x8000 forward and 0x0000 -> 0xFFFF reverse (POS_W=16).
- clr=1: pos <= 0 and err_cnt <= 0 at that edge. clr has priority over a simultaneous step/err for pos and err_cnt; the step or err pulse and the dir update still occur.
- Period timer, in TRACK: increments each cycle, saturating at 2^PER_W-1. On a valid step it is set to 1.
- period and per_valid on a valid step:
  - If the previous step occurred with the timer unsaturated, period <= timer and per_valid <= 1.
  - The first step after reset, and the first step after a stall, do not update period and set per_valid=0.
  - Result: steps at cycles t1 and t2 give period = t2-t1.
- Stall: stall=1 and per_valid=0 when the timer reaches saturation. The next valid step clears stall.

Test Plan:
- Hold qa=qb=1 through reset, release, wait 10 cycles -> err=0, step=0, pos=0, stall=0.
- Forward 00,10,11,01,00, each held 8 cycles -> 4 step pulses, each SYNC_STAGES+1 edges after the input change; pos=4, dir=1, period=8, per_valid=1 from the 2nd step.
- From pos=0, one reverse step 00->01 -> pos=0xFFFF, dir=0. Then forward 01->00 -> pos=0, dir=1.
- Jump 00->11 -> single err pulse, err_cnt=1, no step, pos unchanged. Repeat 300 illegal jumps -> err_cnt=255.
- Assert clr in the same cycle a step is registered at pos=5 -> pos=0, step=1, dir updated. Also assert rst mid-sequence at pos=3 -> all outputs 0 after that edge.
- Bench with PER_W=8: hold inputs for 300 cycles after a step -> stall=1 exactly 254 cycles after that step, per_valid=0. Next step -> stall=0, period unchanged. Step 8 cycles later -> period=8, per_valid=1.
